pwm_ramp_sequencer: RTL and testbench
=====================================

PWM_RAMP_SEQUENCER -- requirements
Module: pwm_ramp_sequencer

Interface
REQ-001 SHALL have parameter STEP, default 1, giving the duty increment/decrement per PWM period (range 1..255).
REQ-002 SHALL have port clk, input, 1, system clock.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port tick, input, 1, one-clk enable strobe from the 100 kHz divider; all PWM timing advances only on tick.
REQ-005 SHALL have port enable, input, 1, level; 0 forces the output off.
REQ-006 SHALL have port cmd_valid, input, 1, new target duty offered.
REQ-007 SHALL have port cmd_duty, input, 8, requested target duty (0 = 0 %, 255 = 100 %).
REQ-008 SHALL have port cmd_ready, output, 1, combinational; 1 when state != RAMP.
REQ-009 SHALL have port pwm_out, output, 1, registered PWM waveform.
REQ-010 SHALL have port duty_cur, output, 8, current ramped duty.
REQ-011 SHALL have port period_start, output, 1, one-clk pulse at each period wrap.
REQ-012 SHALL have port busy, output, 1, registered; 1 while state == RAMP.

Function
REQ-013 SHALL implement an FSM with states IDLE, RAMP and HOLD, plus internal registers cnt[7:0], target[7:0] and duty_active[7:0].
REQ-014 cnt SHALL count 0..254 and wrap to 0, advancing only on cycles with tick=1 and state != IDLE; without tick it holds. Period = 255 ticks.
REQ-015 A wrap event SHALL be tick=1 with cnt==254 and state != IDLE; period_start SHALL pulse high for exactly that cycle.
REQ-016 A command SHALL be accepted when cmd_valid && cmd_ready: target <= cmd_duty. With cmd_ready=0, the command SHALL be ignored and target held.
REQ-017 IDLE: an accepted command SHALL update target only. With enable=1, the FSM SHALL go to RAMP if target != duty_cur, else HOLD.
REQ-018 HOLD: an accepted command with cmd_duty != duty_cur SHALL go to RAMP; otherwise the FSM SHALL stay in HOLD.
REQ-019 RAMP: on each wrap event, duty_cur SHALL move toward target by STEP, computed 9-bit with no wrap-around; if |target-duty_cur| <= STEP, duty_cur <= target and next state = HOLD.
REQ-020 A command accepted on a wrap-event cycle SHALL NOT step duty_cur in that cycle; the first step SHALL occur at the next wrap.
REQ-021 duty_active SHALL load the post-step duty_cur value on every wrap event and hold otherwise, so duty changes only at period boundaries (glitch-free).
REQ-022 pwm_out SHALL be registered as (state != IDLE) && (cnt < duty_active), with one clk latency. duty 0 gives constant low; duty 255 gives constant high.
REQ-023 enable=0 SHALL take priority over every other event (tick, command, wrap). Next state = IDLE, cnt <= 0, pwm_out <= 0. duty_cur, target and duty_active SHALL be retained.
REQ-024 When enable re-asserts, the FSM SHALL resume per REQ-017 with cnt starting from 0.

Reset
REQ-025 rst SHALL immediately force state IDLE, with cnt, target, duty_cur, duty_active, pwm_out, period_start and busy all 0; cmd_ready therefore reads 1.
REQ-026 rst asserted mid-ramp or mid-period SHALL abort the operation with no pending step. After release, the block SHALL behave as from power-up.

Verification
REQ-027 Reset: assert rst mid-period with pwm_out=1 -> pwm_out, duty_cur, busy, period_start = 0 asynchronously; cmd_ready=1.
REQ-028 Ramp up: tick=1 every clk, enable=1, STEP=1, cmd 4 -> duty_cur 1,2,3,4 at successive period_start pulses; busy=1 and cmd_ready=0 until duty_cur=4, then HOLD.
REQ-029 Ramp down with saturation: STEP=3, duty_cur=10, cmd 0 -> duty_cur 7,4,1,0 on successive wraps, then HOLD.
REQ-030 Extremes: duty 0 -> pwm_out low for all 255 ticks; duty 255 -> pwm_out high for all 255 ticks; duty 128 -> high for exactly 128 ticks per period.
REQ-031 Handshake: cmd_valid with cmd 200 during RAMP -> not accepted, target unchanged. Same cmd in HOLD -> accepted in one cycle.
REQ-032 Enable drop mid-ramp, coincident with a wrap -> next cycle IDLE, pwm_out=0, cnt=0, no step taken, duty_cur retained. Re-enable -> ramp continues to target.

Source files
------------

// File: rtl/pwm_ramp_sequencer.sv
// PWM generator whose duty ramps toward a commanded target by STEP once per PWM period.
// The duty used by the comparator is latched only at period wraps, so the waveform never glitches.
module pwm_ramp_sequencer #(
  parameter int unsigned STEP = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       enable,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_duty,
  output logic       cmd_ready,
  output logic       pwm_out,
  output logic [7:0] duty_cur,
  output logic       period_start,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, RAMP, HOLD} state_t;

  localparam logic [8:0] STEP9 = 9'(STEP);
  localparam logic [7:0] STEP8 = 8'(STEP);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] target_q, target_d;
  logic [7:0] duty_cur_q, duty_cur_d;
  logic [7:0] duty_active_q, duty_active_d;
  logic       pwm_q, pwm_d;
  logic       busy_q, busy_d;
  logic       accept;
  logic       wrap;
  logic [8:0] up_diff;
  logic [8:0] dn_diff;

  assign cmd_ready    = (state_q != RAMP);
  assign accept       = enable && cmd_valid && cmd_ready;
  // A disabled cycle never counts as a wrap, so enable=0 also suppresses the step.
  assign wrap         = enable && tick && (state_q != IDLE) && (cnt_q == 8'd254);
  assign up_diff      = {1'b0, target_q} - {1'b0, duty_cur_q};
  assign dn_diff      = {1'b0, duty_cur_q} - {1'b0, target_q};

  assign period_start = wrap;
  assign pwm_out      = pwm_q;
  assign duty_cur     = duty_cur_q;
  assign busy         = busy_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    target_d      = target_q;
    duty_cur_d    = duty_cur_q;
    duty_active_d = duty_active_q;
    pwm_d         = 1'b0;

    if (!enable) begin
      state_d = IDLE;
      cnt_d   = 8'd0;
    end else begin
      if (accept) target_d = cmd_duty;
      if (state_q != IDLE && tick) cnt_d = wrap ? 8'd0 : cnt_q + 8'd1;
      pwm_d = (state_q != IDLE) && (cnt_q < duty_active_q);

      case (state_q)
        IDLE: state_d = (target_d != duty_cur_q) ? RAMP : HOLD;
        HOLD: if (accept && cmd_duty != duty_cur_q) state_d = RAMP;
        RAMP: begin
          // Saturate onto the target when within one step to avoid overshoot or wrap-around.
          if (wrap) begin
            if (target_q >= duty_cur_q) begin
              if (up_diff <= STEP9) begin
                duty_cur_d = target_q;
                state_d    = HOLD;
              end else begin
                duty_cur_d = duty_cur_q + STEP8;
              end
            end else begin
              if (dn_diff <= STEP9) begin
                duty_cur_d = target_q;
                state_d    = HOLD;
              end else begin
                duty_cur_d = duty_cur_q - STEP8;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase

      if (wrap) duty_active_d = duty_cur_d;
    end

    busy_d = (state_d == RAMP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= 8'd0;
      target_q      <= 8'd0;
      duty_cur_q    <= 8'd0;
      duty_active_q <= 8'd0;
      pwm_q         <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      target_q      <= target_d;
      duty_cur_q    <= duty_cur_d;
      duty_active_q <= duty_active_d;
      pwm_q         <= pwm_d;
      busy_q        <= busy_d;
    end
  end

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// Bench for pwm_ramp_sequencer: three instances (STEP 1, 3, 255) share stimulus and are
// checked one at a time; ramp sequences go through an expected-duty queue, duty extremes through a table.
module tb_pwm_ramp_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       enable;
  logic       cmd_valid;
  logic [7:0] cmd_duty;

  logic       a_ready, a_pwm, a_ps, a_busy;
  logic [7:0] a_duty;
  logic       b_ready, b_pwm, b_ps, b_busy;
  logic [7:0] b_duty;
  logic       c_ready, c_pwm, c_ps, c_busy;
  logic [7:0] c_duty;

  always #5 clk = ~clk;

  pwm_ramp_sequencer #(.STEP(1)) dut_a (
    .clk(clk), .rst(rst), .tick(tick), .enable(enable), .cmd_valid(cmd_valid),
    .cmd_duty(cmd_duty), .cmd_ready(a_ready), .pwm_out(a_pwm), .duty_cur(a_duty),
    .period_start(a_ps), .busy(a_busy)
  );

  pwm_ramp_sequencer #(.STEP(3)) dut_b (
    .clk(clk), .rst(rst), .tick(tick), .enable(enable), .cmd_valid(cmd_valid),
    .cmd_duty(cmd_duty), .cmd_ready(b_ready), .pwm_out(b_pwm), .duty_cur(b_duty),
    .period_start(b_ps), .busy(b_busy)
  );

  pwm_ramp_sequencer #(.STEP(255)) dut_c (
    .clk(clk), .rst(rst), .tick(tick), .enable(enable), .cmd_valid(cmd_valid),
    .cmd_duty(cmd_duty), .cmd_ready(c_ready), .pwm_out(c_pwm), .duty_cur(c_duty),
    .period_start(c_ps), .busy(c_busy)
  );

  int         sel;
  logic       s_ready, s_pwm, s_ps, s_busy;
  logic [7:0] s_duty;

  always_comb begin
    s_ready = a_ready;
    s_pwm   = a_pwm;
    s_ps    = a_ps;
    s_busy  = a_busy;
    s_duty  = a_duty;
    case (sel)
      1: begin s_ready = b_ready; s_pwm = b_pwm; s_ps = b_ps; s_busy = b_busy; s_duty = b_duty; end
      2: begin s_ready = c_ready; s_pwm = c_pwm; s_ps = c_ps; s_busy = c_busy; s_duty = c_duty; end
      default: ;
    endcase
  end

  int          checks = 0;
  int          errors = 0;
  byte unsigned exp_q[$];

  typedef struct {
    logic [7:0] duty;
    int         exp_high;
  } vec_t;

  vec_t vecs[5];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic applyStimulus(input logic [7:0] duty);
    cmd_valid = 1'b1;
    cmd_duty  = duty;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic waitWrap(input string name, input int maxc, output int waited, output bit ok);
    ok     = 1'b0;
    waited = 0;
    while (waited < maxc) begin
      if (s_ps === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      waited++;
    end
    if (!ok) timeoutFail(name);
  endtask

  task automatic waitNotBusy(input string name, input int maxc);
    int n;
    n = 0;
    while (s_busy !== 1'b0 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    if (s_busy !== 1'b0) timeoutFail(name);
  endtask

  task automatic drainScoreboard(input string tag);
    byte unsigned exp;
    int           w;
    bit           ok;
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      waitWrap({tag, " wrap"}, 300, w, ok);
      if (!ok) begin
        exp_q.delete();
        break;
      end
      checkOutput({tag, " busy at wrap"}, 32'(s_busy), 32'd1);
      @(negedge clk);
      checkOutput({tag, " duty after wrap"}, 32'(s_duty), 32'(exp));
      checkOutput({tag, " period_start width"}, 32'(s_ps), 32'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   w;
    bit   ok;
    int   ps_seen;
    int   toggles;
    int   high;
    int   n;
    logic prev;

    sel       = 0;
    rst       = 1'b1;
    tick      = 1'b0;
    enable    = 1'b0;
    cmd_valid = 1'b0;
    cmd_duty  = 8'd0;

    vecs[0] = '{duty: 8'd0,   exp_high: 0};
    vecs[1] = '{duty: 8'd255, exp_high: 255};
    vecs[2] = '{duty: 8'd128, exp_high: 128};
    vecs[3] = '{duty: 8'd1,   exp_high: 1};
    vecs[4] = '{duty: 8'd254, exp_high: 254};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset duty_cur", 32'(s_duty), 32'd0);
    checkOutput("reset busy", 32'(s_busy), 32'd0);
    checkOutput("reset cmd_ready", 32'(s_ready), 32'd1);
    checkOutput("reset pwm_out", 32'(s_pwm), 32'd0);
    checkOutput("reset period_start", 32'(s_ps), 32'd0);

    // STEP=1: ramp up, handshake, tick gating, enable drop on a wrap
    enable = 1'b1;
    tick   = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("enable to HOLD busy", 32'(s_busy), 32'd0);
    checkOutput("enable to HOLD ready", 32'(s_ready), 32'd1);
    applyStimulus(8'd4);
    checkOutput("ramp start busy", 32'(s_busy), 32'd1);
    checkOutput("ramp start ready", 32'(s_ready), 32'd0);
    for (int i = 1; i <= 4; i++) exp_q.push_back(byte'(i));
    applyStimulus(8'd200);
    drainScoreboard("rampup");
    checkOutput("rampup done busy", 32'(s_busy), 32'd0);
    checkOutput("rampup done ready", 32'(s_ready), 32'd1);
    checkOutput("rampup ignored cmd duty", 32'(s_duty), 32'd4);

    tick = 1'b0;
    @(negedge clk);
    prev    = s_pwm;
    ps_seen = 0;
    toggles = 0;
    repeat (300) begin
      @(negedge clk);
      if (s_ps === 1'b1) ps_seen++;
      if (s_pwm !== prev) toggles++;
      prev = s_pwm;
    end
    checkOutput("no tick period_start", 32'(ps_seen), 32'd0);
    checkOutput("no tick pwm toggles", 32'(toggles), 32'd0);
    tick = 1'b1;

    applyStimulus(8'd200);
    checkOutput("hold accept busy", 32'(s_busy), 32'd1);

    waitWrap("drop wrap", 300, w, ok);
    enable = 1'b0;
    @(negedge clk);
    checkOutput("drop duty retained", 32'(s_duty), 32'd4);
    checkOutput("drop busy", 32'(s_busy), 32'd0);
    checkOutput("drop pwm_out", 32'(s_pwm), 32'd0);
    checkOutput("drop cmd_ready", 32'(s_ready), 32'd1);
    repeat (3) @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    checkOutput("reenable busy", 32'(s_busy), 32'd1);
    waitWrap("reenable wrap", 300, w, ok);
    checkOutput("reenable cnt from 0", 32'(w), 32'd254);
    @(negedge clk);
    checkOutput("reenable first step", 32'(s_duty), 32'd5);

    // STEP=3: ramp to 10 then down to 0 with saturation
    sel = 1;
    doReset();
    checkOutput("step3 reset duty", 32'(s_duty), 32'd0);
    exp_q.push_back(8'd3);
    exp_q.push_back(8'd6);
    exp_q.push_back(8'd9);
    exp_q.push_back(8'd10);
    applyStimulus(8'd10);
    drainScoreboard("up3");
    exp_q.push_back(8'd7);
    exp_q.push_back(8'd4);
    exp_q.push_back(8'd1);
    exp_q.push_back(8'd0);
    applyStimulus(8'd0);
    drainScoreboard("down3");
    checkOutput("down3 hold busy", 32'(s_busy), 32'd0);

    // STEP=255: high-time per period for a table of duties
    sel = 2;
    doReset();
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].duty);
      waitNotBusy($sformatf("duty %0d settle", vecs[i].duty), 600);
      @(negedge clk);
      high = 0;
      repeat (255) begin
        @(negedge clk);
        if (s_pwm === 1'b1) high++;
      end
      checkOutput($sformatf("duty %0d high ticks", vecs[i].duty), 32'(high), 32'(vecs[i].exp_high));
    end

    n = 0;
    while (s_pwm !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async reset pwm_out", 32'(s_pwm), 32'd0);
    checkOutput("async reset duty_cur", 32'(s_duty), 32'd0);
    checkOutput("async reset busy", 32'(s_busy), 32'd0);
    checkOutput("async reset period_start", 32'(s_ps), 32'd0);
    checkOutput("async reset cmd_ready", 32'(s_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("post reset duty", 32'(s_duty), 32'd0);
    checkOutput("post reset busy", 32'(s_busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
